// File: rtl/vram_access_arbiter_pkg.sv
// vram_arb_pkg: shared types and helpers for the VRAM access arbiter.
// Starvation guard is enabled by VRAM_ARB_STARVE_GUARD_EN.
package vram_arb_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_32 = 2'd2
  } mem_size_t;

  function automatic logic [3:0] onehot_to_idx(
    input logic [MAX_CH-1:0] oh
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Channel request/ack bundle and registered VRAM port of the arbiter.
// master = requester side, slave = arbiter.
interface vram_access_arbiter_if #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  import vram_arb_pkg::*;

  logic                     SLOT_EN;
  logic [NUM_CH-1:0]        CH_REQ;
  logic [NUM_CH-1:0]        CH_ACK;
  logic [NUM_CH-1:0]        CH_HOLD;
  logic [NUM_CH*ADDR_W-1:0] CH_ADDR;
  logic [NUM_CH-1:0]        CH_WE;
  logic [NUM_CH*2-1:0]      CH_SIZE;
  logic [NUM_CH*DATA_W-1:0] CH_WDATA;
  logic [ADDR_W-1:0]        MEM_ADDR;
  logic                     MEM_WE_N;
  mem_size_t                MEM_SIZE;
  logic [DATA_W-1:0]        MEM_WDATA;
  logic [NUM_CH-1:0]        GRANT;
  logic                     GRANT_VALID;

  modport master (
    output SLOT_EN, CH_REQ, CH_HOLD,
    output CH_ADDR, CH_WE, CH_SIZE, CH_WDATA,
    input  CH_ACK, MEM_ADDR, MEM_WE_N,
    input  MEM_SIZE, MEM_WDATA, GRANT, GRANT_VALID
  );

  modport slave (
    input  SLOT_EN, CH_REQ, CH_HOLD,
    input  CH_ADDR, CH_WE, CH_SIZE, CH_WDATA,
    output CH_ACK, MEM_ADDR, MEM_WE_N,
    output MEM_SIZE, MEM_WDATA, GRANT, GRANT_VALID
  );

endinterface

// File: rtl/vram_access_arbiter_rr_pick.sv
// vram_arb_rr_pick: rotate the request vector by the pointer and
// priority-encode, giving the first requester at or after ptr_i.
module vram_arb_rr_pick #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  logic [N-1:0] rot;

  assign rot = N'({req_i, req_i} >> ptr_i);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        idx_o   = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter: per-slot VRAM grant, urgent fixed priority + round-robin.
// Define VRAM_ARB_STARVE_GUARD_EN to let starved channels outrank urgent ones.
module vram_access_arbiter
  import vram_arb_pkg::*;
#(
  parameter int                NUM_CH       = 8,
  parameter int                ADDR_W       = 17,
  parameter int                DATA_W       = 32,
  parameter logic [MAX_CH-1:0] URGENT_MASK  = 16'h0003,
  parameter int                DEFAULT_CH   = 0,
  parameter int                STARVE_LIMIT = 15
) (
  input logic                  CLK21M,
  input logic                  RESET_N,
  vram_access_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_CH);
  typedef logic [PW-1:0] ch_idx_t;

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_dw
    $error("vram_access_arbiter: DATA_W must be 8, 16 or 32");
  end
  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_nch
    $error("vram_access_arbiter: NUM_CH must be 2..16");
  end
  if (DEFAULT_CH < 0 || DEFAULT_CH >= NUM_CH) begin : g_bad_def
    $error("vram_access_arbiter: DEFAULT_CH out of range");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_lim
    $error("vram_access_arbiter: STARVE_LIMIT must fit 4 bits");
  end

  logic [NUM_CH-1:0] urg;
  assign urg = URGENT_MASK[NUM_CH-1:0];

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  mem_size_t         size_a  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign addr_a[g]  = bus.CH_ADDR[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.CH_WDATA[g*DATA_W +: DATA_W];
    assign size_a[g]  = mem_size_t'(bus.CH_SIZE[2*g +: 2]);
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_n_q, we_n_d;
  mem_size_t         size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              gv_q, gv_d;
  ch_idx_t           ptr_q, ptr_d;

  logic [NUM_CH-1:0] tog, pend, starved;
  logic [MAX_CH-1:0] urg_ext, urg_low, stv_ext, stv_low;
  ch_idx_t           urg_idx, stv_idx, rr_idx, win;
  logic              rr_found, hit, rr_win;

  // A held urgent channel is pending without owning a toggle.
  assign tog  = bus.CH_REQ ^ ack_q;
  assign pend = tog | (urg & bus.CH_HOLD);

  assign urg_ext = MAX_CH'(pend & urg);
  assign urg_low = urg_ext & (~urg_ext + MAX_CH'(1));
  assign urg_idx = ch_idx_t'(onehot_to_idx(urg_low));
  assign stv_ext = MAX_CH'(starved);
  assign stv_low = stv_ext & (~stv_ext + MAX_CH'(1));
  assign stv_idx = ch_idx_t'(onehot_to_idx(stv_low));

  vram_arb_rr_pick #(
    .N  (NUM_CH),
    .PW (PW)
  ) u_rr (
    .req_i   (pend & ~urg),
    .ptr_i   (ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx)
  );

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [3:0] cnt_q [NUM_CH];
  logic [3:0] cnt_d [NUM_CH];

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      starved[i] = !urg[i] && pend[i] &&
                   (cnt_q[i] >= 4'(STARVE_LIMIT));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.SLOT_EN) begin
        if (urg[i] || !pend[i] || grant_d[i]) cnt_d[i] = '0;
        else if (cnt_q[i] != 4'hf) cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign starved = '0;
`endif

  always_comb begin
    win    = '0;
    hit    = 1'b0;
    rr_win = 1'b0;
    if (|starved) begin
      win    = stv_idx;
      hit    = 1'b1;
      rr_win = 1'b1;
    end else if (|(pend & urg)) begin
      win = urg_idx;
      hit = 1'b1;
    end else if (rr_found) begin
      win    = rr_idx;
      hit    = 1'b1;
      rr_win = 1'b1;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    we_n_d  = we_n_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    ptr_d   = ptr_q;
    gv_d    = 1'b0;
    if (bus.SLOT_EN) begin
      grant_d = '0;
      if (hit) begin
        addr_d         = addr_a[win];
        we_n_d         = ~bus.CH_WE[win];
        size_d         = size_a[win];
        grant_d[win]   = 1'b1;
        gv_d           = 1'b1;
        if (bus.CH_WE[win]) wdata_d = wdata_a[win];
        if (tog[win]) ack_d[win] = ~ack_q[win];
        if (rr_win) begin
          ptr_d = (int'(win) == NUM_CH - 1) ? '0
                : win + ch_idx_t'(1);
        end
      end else begin
        addr_d = addr_a[DEFAULT_CH];
        we_n_d = 1'b1;
        size_d = WIDTH_32;
      end
    end
  end

  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q  <= '1;
      we_n_q  <= 1'b1;
      size_q  <= WIDTH_16;
      wdata_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      gv_q    <= 1'b0;
      ptr_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      gv_q    <= gv_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.MEM_ADDR    = addr_q;
  assign bus.MEM_WE_N    = we_n_q;
  assign bus.MEM_SIZE    = size_q;
  assign bus.MEM_WDATA   = wdata_q;
  assign bus.GRANT       = grant_q;
  assign bus.GRANT_VALID = gv_q;
  assign bus.CH_ACK      = ack_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb_vram_access_arbiter: directed + random stimulus against a slot-level model.
// Build with VRAM_ARB_STARVE_GUARD_EN defined to cover the starvation guard.
module tb_vram_access_arbiter;
  import vram_arb_pkg::*;

  localparam int         N     = 8;
  localparam int         AW    = 17;
  localparam int         DW    = 32;
  localparam int         LIMIT = 15;
  localparam logic [7:0] URG   = 8'h03;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  vram_access_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_access_arbiter #(
    .NUM_CH       (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .URGENT_MASK  (16'h0003),
    .DEFAULT_CH   (0),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK21M  (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [AW-1:0] ch_addr(int i);
    return bus.CH_ADDR[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] ch_wdata(int i);
    return bus.CH_WDATA[i*DW +: DW];
  endfunction

  // Behavioural model: expected VRAM port state after each edge.
  logic [N-1:0]  m_ack, m_grant;
  logic [AW-1:0] m_addr;
  logic          m_we_n, m_gv;
  logic [1:0]    m_size;
  logic [DW-1:0] m_wdata;
  int            m_ptr;
  int            m_wait [N];

  task automatic m_reset();
    m_ack   = '0;
    m_grant = '0;
    m_addr  = '1;
    m_we_n  = 1'b1;
    m_gv    = 1'b0;
    m_size  = 2'd1;
    m_wdata = '0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic m_slot();
    bit pend [N];
    int w  = -1;
    bit rr = 0;
    for (int i = 0; i < N; i++)
      pend[i] = (bus.CH_REQ[i] != m_ack[i]) || (URG[i] && bus.CH_HOLD[i]);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    for (int i = 0; i < N; i++)
      if (w < 0 && !URG[i] && pend[i] && m_wait[i] >= LIMIT) begin
        w  = i;
        rr = 1;
      end
`endif
    for (int i = 0; i < N; i++)
      if (w < 0 && URG[i] && pend[i]) w = i;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (w < 0 && !URG[j] && pend[j]) begin
        w  = j;
        rr = 1;
      end
    end
    for (int i = 0; i < N; i++)
      if (!URG[i] && pend[i] && i != w)
        m_wait[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
      else
        m_wait[i] = 0;
    if (w < 0) begin
      m_addr  = ch_addr(0);
      m_we_n  = 1'b1;
      m_size  = 2'd2;
      m_grant = '0;
    end else begin
      m_addr  = ch_addr(w);
      m_we_n  = !bus.CH_WE[w];
      m_size  = bus.CH_SIZE[2*w +: 2];
      if (bus.CH_WE[w]) m_wdata = ch_wdata(w);
      m_grant = N'(1) << w;
      m_gv    = 1'b1;
      if (bus.CH_REQ[w] != m_ack[w]) m_ack[w] = ~m_ack[w];
      if (rr) m_ptr = (w + 1) % N;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        m_gv = 1'b0;
        if (bus.SLOT_EN) m_slot();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ack",   bus.CH_ACK,      m_ack);
      chk("addr",  bus.MEM_ADDR,    m_addr);
      chk("we_n",  bus.MEM_WE_N,    m_we_n);
      chk("size",  bus.MEM_SIZE,    m_size);
      chk("wdata", bus.MEM_WDATA,   m_wdata);
      chk("grant", bus.GRANT,       m_grant);
      chk("gv",    bus.GRANT_VALID, m_gv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot();
    bus.SLOT_EN = 1'b1;
    tick();
    bus.SLOT_EN = 1'b0;
  endtask

  task automatic tg(int i);
    bus.CH_REQ[i] = ~bus.CH_REQ[i];
  endtask

  initial begin
    bus.SLOT_EN  = 1'b0;
    bus.CH_REQ   = '0;
    bus.CH_HOLD  = '0;
    bus.CH_WE    = '0;
    bus.CH_SIZE  = {N{2'd1}};
    bus.CH_WDATA = '0;
    for (int i = 0; i < N; i++) bus.CH_ADDR[i*AW +: AW] = AW'($urandom);
    repeat (3) tick();
    chk("rst_addr", bus.MEM_ADDR, 17'h1FFFF);
    chk("rst_we_n", bus.MEM_WE_N, 1);
    chk("rst_size", bus.MEM_SIZE, 1);
    chk("rst_gv",   bus.GRANT_VALID, 0);
    rst_n = 1'b1;
    tick();

    repeat (4) begin
      slot();
      chk("idle_addr",  bus.MEM_ADDR, ch_addr(0));
      chk("idle_size",  bus.MEM_SIZE, 2);
      chk("idle_grant", bus.GRANT, 0);
      chk("idle_ack",   bus.CH_ACK, 0);
    end

    tg(2); tg(3); tg(5);
    slot(); chk("rr_g2", bus.GRANT, 8'h04);
    slot(); chk("rr_g3", bus.GRANT, 8'h08);
    slot(); chk("rr_g5", bus.GRANT, 8'h20);
    chk("rr_ack", bus.CH_ACK, 8'h2C);

    bus.CH_ADDR[4*AW +: AW]  = 17'h12345;
    bus.CH_WDATA[4*DW +: DW] = 32'hDEADBEEF;
    bus.CH_WE[4]   = 1'b1;
    bus.CH_HOLD[0] = 1'b1;
    tg(4);
    repeat (3) begin
      slot();
      chk("hold_g0",  bus.GRANT, 8'h01);
      chk("hold_ack", bus.CH_ACK, 8'h2C);
    end
    bus.CH_HOLD[0] = 1'b0;
    slot();
    chk("w4_grant", bus.GRANT, 8'h10);
    chk("w4_we_n",  bus.MEM_WE_N, 0);
    chk("w4_wdata", bus.MEM_WDATA, 32'hDEADBEEF);
    chk("w4_addr",  bus.MEM_ADDR, 17'h12345);
    chk("w4_ack",   bus.CH_ACK, 8'h3C);

    tg(6);
    slot(); chk("p7_g6", bus.GRANT, 8'h40);
    tg(2); tg(6);
    slot(); chk("wrap_g2", bus.GRANT, 8'h04);
    slot(); chk("wrap_g6", bus.GRANT, 8'h40);

    bus.CH_HOLD[1] = 1'b1;
    tg(4);
    for (int s = 1; s <= 16; s++) begin
      slot();
`ifdef VRAM_ARB_STARVE_GUARD_EN
      chk("starve_g", bus.GRANT, (s == 16) ? 8'h10 : 8'h02);
`else
      chk("starve_g", bus.GRANT, 8'h02);
`endif
    end
    bus.CH_HOLD[1] = 1'b0;
    slot();

    for (int c = 0; c < 3000; c++) begin
      bus.SLOT_EN = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.CH_REQ = bus.CH_REQ ^ (N'($urandom) & N'($urandom));
      bus.CH_HOLD = N'($urandom) & N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          bus.CH_ADDR[i*AW +: AW]  = AW'($urandom);
          bus.CH_WDATA[i*DW +: DW] = $urandom;
          bus.CH_WE[i]             = 1'($urandom);
          bus.CH_SIZE[2*i +: 2]    = 2'($urandom_range(0, 2));
        end
      end
      tick();
    end
    bus.SLOT_EN = 1'b0;
    bus.CH_HOLD = '0;
    tick();
    repeat (10) slot();

    bus.CH_WE[3] = 1'b1;
    bus.CH_WDATA[3*DW +: DW] = 32'hCAFEF00D;
    tg(3);
    slot();
    chk("ar_pre_grant", bus.GRANT, 8'h08);
    chk("ar_pre_we_n",  bus.MEM_WE_N, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we_n",  bus.MEM_WE_N, 1);
    chk("ar_ack",   bus.CH_ACK, 0);
    chk("ar_grant", bus.GRANT, 0);
    chk("ar_gv",    bus.GRANT_VALID, 0);
    repeat (2) tick();
    bus.CH_REQ = '0;
    rst_n = 1'b1;
    tick();
    repeat (4) slot();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Parametrised, N-channel successor to the VDP VRAM access arbiter.
- One grant per access slot (SLOT_EN); the winning channel's address, data, write-enable and transfer size are registered onto the single VRAM port.
- Channels use toggle handshakes (REQ != ACK means pending). A per-channel URGENT mask gives fixed priority to display/sprite fetch; all other channels share round-robin.
- Sits between the display, sprite, CPU and command engines and the VRAM controller, in the same position as the current fixed arbiter.

Parameters:
- NUM_CH, 8, number of requesting channels (2..16).
- ADDR_W, 17, VRAM address width.
- DATA_W, 32, write data width; must be 8, 16 or 32.
- URGENT_MASK, 8'h03, bit i=1 gives channel i fixed priority.
- DEFAULT_CH, 0, channel whose address is driven on idle slots (display fetch).
- STARVE_LIMIT, 15, number of slots a non-urgent channel may wait (optional feature only).

Ports:
- CLK21M  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- SLOT_EN  in  1  one-cycle strobe marking a VRAM access slot.
- CH_REQ  in  NUM_CH  per-channel request toggle.
- CH_ACK  out  NUM_CH  per-channel acknowledge toggle.
- CH_HOLD  in  NUM_CH  level; urgent channel claims slots while high, without a toggle.
- CH_ADDR  in  NUM_CH*ADDR_W  per-channel address.
- CH_WE  in  NUM_CH  per-channel access type: 1=write, 0=read.
- CH_SIZE  in  NUM_CH*2  per-channel transfer size (mem_size_t).
- CH_WDATA  in  NUM_CH*DATA_W  per-channel write data.
- MEM_ADDR  out  ADDR_W  registered VRAM address.
- MEM_WE_N  out  1  registered write enable, active low.
- MEM_SIZE  out  2  registered transfer size.
- MEM_WDATA  out  DATA_W  registered write data.
- GRANT  out  NUM_CH  one-hot grant for the current slot; all-zero when idle.
- GRANT_VALID  out  1  high for the one cycle after a granted slot.

Behaviour:
- Reset values: MEM_ADDR all ones; MEM_WE_N=1; MEM_SIZE=WIDTH_16; MEM_WDATA=0; CH_ACK=0; GRANT=0; GRANT_VALID=0; round-robin pointer=0.
- Evaluation happens only on cycles with SLOT_EN=1. Outputs hold between slots, except GRANT_VALID, which clears after one cycle.
- Pending(i) = (CH_REQ[i] != CH_ACK[i]) or (URGENT_MASK[i] and CH_HOLD[i]).
- Priority:
  - (1) Urgent pending channels; lowest index wins.
  - (2) Non-urgent pending channels, round-robin. Search starts at pointer and wraps modulo NUM_CH. After a non-urgent grant, pointer = winner+1 (wraps to 0 after NUM_CH-1).
  - (3) No pending channel: idle slot. MEM_ADDR=CH_ADDR[DEFAULT_CH], MEM_WE_N=1, MEM_SIZE=WIDTH_32, GRANT=0.
- On a grant to channel w, registered on the SLOT_EN edge (latency 1 clock):
  - MEM_ADDR=CH_ADDR[w], MEM_WE_N=~CH_WE[w], MEM_SIZE=CH_SIZE[w], GRANT=1<<w, GRANT_VALID=1.
  - MEM_WDATA=CH_WDATA[w] on writes; reads leave it unchanged.
  - CH_ACK[w] toggles only if the grant came from a toggle request. A grant due only to CH_HOLD does not toggle the ack.
- Urgent grants do not move the round-robin pointer.
- A new toggle arriving on the same edge as its ack flip is seen at the next slot; there is no lost or double grant.
- A request toggled twice between slots looks idle. This is legal: the requester owns that hazard.
- A width violation (DATA_W illegal, NUM_CH out of range) is flagged by an elaboration-time assertion.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial write may complete, because MEM_WE_N forces to 1 asynchronously.

Optional Feature:
- Macro: VRAM_ARB_STARVE_GUARD_EN.
- Defined:
  - Each non-urgent channel has a 4-bit saturating wait counter. It increments on each slot in which the channel is pending but not granted, and clears on grant or when not pending.
  - When a counter reaches STARVE_LIMIT, that channel outranks urgent channels for one slot; lowest index wins if several are starved.
  - Its grant moves the pointer as in the normal round-robin case.
- Not defined: no counters; strict priority as described above, and urgent channels may starve the others indefinitely.

Decomposition:
- Package vram_arb_pkg:
  - mem_size_t enum {WIDTH_8=2'd0, WIDTH_16=2'd1, WIDTH_32=2'd2}, replacing the MEMORY_WIDTH_* defines.
  - Function onehot_to_idx.
  - Constant MAX_CH=16.
- Sub-module vram_arb_rr_pick: combinational rotate-and-priority-encode over NUM_CH bits. Inputs: pending vector and pointer. Outputs: found flag and index.

Test Plan:
- Reset release, no requests, 4 slots -> MEM_ADDR=CH_ADDR[0] each slot, MEM_WE_N=1, MEM_SIZE=WIDTH_32, GRANT=0, CH_ACK=0.
- Channels 2,3,5 toggle together (reads) -> grants 2,3,5 on consecutive slots; each ack flips once; pointer=6.
- CH_HOLD[0]=1 for 3 slots while channel 4 writes 32'hDEADBEEF at 17'h1_2345 -> 3 grants to ch0 with no ack flip; then ch4 gets MEM_WE_N=0, MEM_WDATA=32'hDEADBEEF, MEM_ADDR=17'h12345, and CH_ACK[4] toggles.
- Pointer at 7, channels 2 and 6 pending -> ch2 granted first (wrap), then ch6.
- With VRAM_ARB_STARVE_GUARD_EN: CH_HOLD[1]=1 continuously, ch4 pending -> ch4 granted on slot 16; without the macro ch4 is never granted.
- RESET_N pulled low in the cycle after a write grant -> MEM_WE_N=1, CH_ACK=0 and GRANT=0 immediately, without waiting for a clock.
